// File: rtl/udp_pkg.sv
// Shared UDP definitions for the encoder/decoder pair: FSM states, protocol
// constants and the tail-byte masking helper.
package udp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FOLD1,
        ST_FOLD2,
        ST_HDR0,
        ST_HDR1,
        ST_PAY
    } udp_state_t;

    localparam logic [15:0] UDP_PROTO   = 16'h0011;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    // Zero the bytes of a big-endian word that lie past the end of the payload;
    // rem is the number of payload bytes left, counting from this word.
    function automatic logic [31:0] mask_tail(input logic [31:0] w, input logic [15:0] rem);
        if (rem >= 16'd4) begin
            return w;
        end
        case (rem[1:0])
            2'd3:    return {w[31:8], 8'h00};
            2'd2:    return {w[31:16], 16'h0000};
            2'd1:    return {w[31:24], 24'h000000};
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/udp_csum16.sv
// 16-bit adder with carry out; applied twice (FOLD1/FOLD2) it folds a 32-bit
// ones-complement accumulator down to 16 bits.
module udp_csum16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [16:0] o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/udp_encoder.sv
// UDP datagram encoder: buffers a payload, computes the pseudo-header checksum
// and emits header plus masked payload words.
module udp_encoder
    import udp_pkg::*;
#(
    parameter int MAX_WORDS = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dest_ip,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dest_port,
    input  logic [15:0] i_len_data,
    input  logic        i_start,
    input  logic [31:0] i_data_in,
    input  logic        i_wr_in,
    output logic        o_ready,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_fin,
    output logic        o_err
);

    localparam int          AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [15:0] MAX_BYTES = 16'(4 * MAX_WORDS);

    udp_state_t     r_state;
    logic [15:0]    r_src_port;
    logic [15:0]    r_dest_port;
    logic [15:0]    r_len;
    logic [15:0]    r_udp_len;
    logic [15:0]    r_last;
    logic [31:0]    r_acc;
    logic [AW-1:0]  r_wr_cnt;
    logic [AW-1:0]  r_rd_cnt;
    logic [31:0]    r_mem [MAX_WORDS];
    logic [31:0]    r_data;
    logic           r_valid;
    logic           r_fin;
    logic           r_err;
    logic           r_ready;

    logic [15:0]    w_udp_len_in;
    logic [15:0]    w_last_in;
    logic           w_len_ok;
    logic [31:0]    w_seed;
    logic [15:0]    w_rem;
    logic [31:0]    w_word;
    logic [16:0]    w_fold;
    logic [15:0]    w_csum;
    logic [15:0]    w_csum_tx;
    logic           w_wr_last;
    logic           w_rd_last;

    assign w_udp_len_in = i_len_data + UDP_HDR_LEN;
    assign w_last_in    = ((i_len_data + 16'd3) >> 2) - 16'd1;
    assign w_len_ok     = (i_len_data != 16'd0) && (i_len_data <= MAX_BYTES);
    assign w_seed       = 32'(i_src_ip[31:16]) + 32'(i_src_ip[15:0])
                        + 32'(i_dest_ip[31:16]) + 32'(i_dest_ip[15:0])
                        + 32'(UDP_PROTO) + 32'(w_udp_len_in)
                        + 32'(i_src_port) + 32'(i_dest_port) + 32'(w_udp_len_in);

    assign w_rem     = r_len - {{(14-AW){1'b0}}, r_wr_cnt, 2'b00};
    assign w_word    = mask_tail(i_data_in, w_rem);
    assign w_wr_last = ({{(16-AW){1'b0}}, r_wr_cnt} == r_last);
    assign w_rd_last = ({{(16-AW){1'b0}}, r_rd_cnt} == r_last);

    // After FOLD1 the upper half holds only the carry, so the same add
    // performs the end-around carry in FOLD2.
    udp_csum16 u_csum (
        .i_a   (r_acc[15:0]),
        .i_b   (r_acc[31:16]),
        .o_sum (w_fold)
    );

    assign w_csum    = ~r_acc[15:0];
    assign w_csum_tx = (w_csum == 16'h0000) ? 16'hFFFF : w_csum;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_src_port  <= '0;
            r_dest_port <= '0;
            r_len       <= '0;
            r_udp_len   <= '0;
            r_last      <= '0;
            r_acc       <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_fin       <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_len_ok) begin
                            r_src_port  <= i_src_port;
                            r_dest_port <= i_dest_port;
                            r_len       <= i_len_data;
                            r_udp_len   <= w_udp_len_in;
                            r_last      <= w_last_in;
                            r_acc       <= w_seed;
                            r_wr_cnt    <= '0;
                            r_ready     <= 1'b0;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_wr_in) begin
                        r_acc    <= r_acc + 32'(w_word[31:16]) + 32'(w_word[15:0]);
                        r_wr_cnt <= r_wr_cnt + AW'(1);
                        if (w_wr_last) begin
                            r_state <= ST_FOLD1;
                        end
                    end
                end
                ST_FOLD1: begin
                    r_acc   <= {15'd0, w_fold};
                    r_state <= ST_FOLD2;
                end
                ST_FOLD2: begin
                    r_acc   <= {15'd0, w_fold};
                    r_data  <= {r_src_port, r_dest_port};
                    r_valid <= 1'b1;
                    r_state <= ST_HDR0;
                end
                ST_HDR0: begin
                    r_data  <= {r_udp_len, w_csum_tx};
                    r_state <= ST_HDR1;
                end
                ST_HDR1: begin
                    r_data   <= r_mem[0];
                    r_fin    <= (r_last == 16'd0);
                    r_rd_cnt <= AW'(1);
                    r_state  <= ST_PAY;
                end
                ST_PAY: begin
                    if (r_fin) begin
                        r_data   <= '0;
                        r_valid  <= 1'b0;
                        r_fin    <= 1'b0;
                        r_rd_cnt <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_data   <= r_mem[r_rd_cnt];
                        r_fin    <= w_rd_last;
                        r_rd_cnt <= r_rd_cnt + AW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload buffer is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && (r_state == ST_LOAD) && i_wr_in) begin
            r_mem[r_wr_cnt] <= w_word;
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_fin   = r_fin;
    assign o_err   = r_err;

endmodule

// File: tb/tb_udp_encoder.sv
// Scoreboard bench for udp_encoder: a reference checksum model fills the
// expected-word queue, a negedge monitor drains and compares it.
module tb_udp_encoder;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src_ip, dest_ip;
    logic [15:0] src_port, dest_port, len_data;
    logic        start, wr_in;
    logic [31:0] data_in;
    logic        ready, valid, fin, err;
    logic [31:0] data;

    always #5 clk = ~clk;

    udp_encoder #(.MAX_WORDS(MAXW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_src_ip    (src_ip),
        .i_dest_ip   (dest_ip),
        .i_src_port  (src_port),
        .i_dest_port (dest_port),
        .i_len_data  (len_data),
        .i_start     (start),
        .i_data_in   (data_in),
        .i_wr_in     (wr_in),
        .o_ready     (ready),
        .o_data      (data),
        .o_valid     (valid),
        .o_fin       (fin),
        .o_err       (err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;
    bit mon_en = 1'b0;
    bit in_pkt = 1'b0;

    logic [32:0] sb_q [$];
    logic [31:0] pay [MAXW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask_w(input logic [31:0] w, input int k, input int len);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++) begin
            if (4 * k + b >= len) r[31 - 8*b -: 8] = 8'h00;
        end
        return r;
    endfunction

    function automatic logic [15:0] model_csum(input logic [31:0] sip, input logic [31:0] dip,
                                               input logic [15:0] sp, input logic [15:0] dp,
                                               input int len);
        logic [31:0] s;
        logic [31:0] w;
        logic [15:0] c;
        logic [15:0] ulen;
        ulen = 16'(len + 8);
        s = 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0])
          + 32'h11 + 32'(ulen) + 32'(ulen) + 32'(sp) + 32'(dp);
        for (int k = 0; k < (len + 3) / 4; k++) begin
            w = mask_w(pay[k], k, len);
            s = s + 32'(w[31:16]) + 32'(w[15:0]);
        end
        while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
        c = ~s[15:0];
        if (c == 16'h0000) c = 16'hFFFF;
        return c;
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (mon_en) begin
            if (valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'(valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (!in_pkt) begin
                        check("hdr0_latency", 32'(cyc - t_acc + 1), 32'd3);
                        in_pkt = 1'b1;
                    end
                    check("data", data, e[31:0]);
                    check("fin", 32'(fin), 32'(e[32]));
                    if (fin) in_pkt = 1'b0;
                end
            end else begin
                check("idle_data", data, 32'd0);
                if (in_pkt) begin
                    check("valid_gap", 32'(valid), 32'd1);
                    in_pkt = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic send(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                        input logic [15:0] dp, input int len, input bit abort);
        int nw;
        int n;
        nw = (len + 3) / 4;
        if (!abort) begin
            sb_q.push_back({1'b0, sp, dp});
            sb_q.push_back({1'b0, 16'(len + 8), model_csum(sip, dip, sp, dp, len)});
            for (int k = 0; k < nw; k++) sb_q.push_back({(k == nw - 1), mask_w(pay[k], k, len)});
        end
        wait_ready();
        src_ip = sip; dest_ip = dip; src_port = sp; dest_port = dp;
        len_data = 16'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < nw; k++) begin
            wr_in = 1'b1;
            data_in = pay[k];
            @(posedge clk); #1;
            t_acc = cyc;
            if (abort) begin
                wr_in = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check("abort_ready", 32'(ready), 32'd1);
                check("abort_valid", 32'(valid), 32'd0);
                check("abort_fin", 32'(fin), 32'd0);
                break;
            end
        end
        wr_in = 1'b0;
        data_in = 32'h0;
        n = 0;
        while ((sb_q.size() != 0 || valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic start_bad(input int len);
        wait_ready();
        len_data = 16'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_err_pulse", 32'(err), 32'd1);
        check("bad_ready", 32'(ready), 32'd1);
        check("bad_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        check("bad_err_clear", 32'(err), 32'd0);
        check("bad_ready2", 32'(ready), 32'd1);
    endtask

    task automatic load_hello();
        pay[0] = 32'h48656c6c;
        pay[1] = 32'h6f20576f;
        pay[2] = 32'h726c64a5;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr_in = 1'b0; data_in = '0;
        src_ip = '0; dest_ip = '0; src_port = '0; dest_port = '0; len_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_fin", 32'(fin), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        load_hello();
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 11, 1'b0);

        pay[0] = 32'h00000000;
        send(32'h0, 32'h0, 16'h0, 16'h0, 4, 1'b0);
        pay[0] = 32'hffd60000;
        send(32'h0, 32'h0, 16'h0, 16'h0, 4, 1'b0);
        pay[0] = 32'haabbccdd;
        pay[1] = 32'heeff1122;
        send(32'h0, 32'h0, 16'h0, 16'h0, 5, 1'b0);

        start_bad(0);
        start_bad(4 * MAXW + 1);

        load_hello();
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 11, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        load_hello();
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 11, 1'b0);

        for (int k = 0; k < MAXW; k++) pay[k] = $urandom;
        send($urandom, $urandom, 16'($urandom), 16'($urandom), 4 * MAXW, 1'b0);
        for (int k = 0; k < MAXW; k++) pay[k] = $urandom;
        send($urandom, $urandom, 16'($urandom), 16'($urandom), 4 * MAXW - 1, 1'b0);
        pay[0] = $urandom;
        send($urandom, $urandom, 16'h1234, 16'h5678, 1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
